spi_periph: RTL



---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_shift_core.sv | 96 +++++++++
 rtl/spi_periph.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral: engine states,
// APB register offsets and STATUS bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_TXD    = 4'h4;
    localparam logic [3:0] OFF_RXD    = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RXV  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_WCOL = 3;

endpackage

// File: rtl/spi_shift_core.sv
// Single-byte SPI master shift engine: LEAD / 16 half-periods / TRAIL,
// each phase DIV+1 clocks. MSB first, CPOL/CPHA selectable.
module spi_shift_core
    import spi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte_in,
    input  logic       i_cpol,
    input  logic       i_cpha,
    input  logic [7:0] i_div,
    input  logic       i_miso,
    output logic       o_done,
    output logic [7:0] o_byte_out,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n
);
    spi_state_e r_state;
    spi_state_e w_next;
    logic [7:0] r_div_cnt;
    logic [3:0] r_edge_cnt;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;
    logic       w_cnt_done;
    logic       w_lead_edge;
    logic       w_trail_edge;
    logic       w_sample;
    logic       w_shift;

    assign w_cnt_done   = (r_div_cnt == i_div);
    // Leading SCLK edges: entering half-period 0 (end of LEAD) and entering every even one.
    assign w_lead_edge  = (r_state == LEAD && w_cnt_done) ||
                          (r_state == SHIFT && w_cnt_done && r_edge_cnt[0] && r_edge_cnt != 4'd15);
    assign w_trail_edge = (r_state == SHIFT) && w_cnt_done && !r_edge_cnt[0];
    assign w_sample     = i_cpha ? w_trail_edge : w_lead_edge;
    // With CPHA=1 the first leading edge keeps bit 7 on MOSI, so only leading edges inside SHIFT shift.
    assign w_shift      = i_cpha ? (w_lead_edge && r_state == SHIFT) : w_trail_edge;

    assign o_mosi     = r_tx_sr[7];
    assign o_byte_out = r_rx_sr;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        o_done = 1'b0;
        o_busy = 1'b1;
        o_cs_n = 1'b0;
        o_sclk = i_cpol;
        unique case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                o_cs_n = 1'b1;
                if (i_start) w_next = LEAD;
            end
            LEAD:  if (w_cnt_done) w_next = SHIFT;
            SHIFT: begin
                o_sclk = i_cpol ^ ~r_edge_cnt[0];
                if (w_cnt_done && r_edge_cnt == 4'd15) w_next = TRAIL;
            end
            TRAIL: if (w_cnt_done) begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Phase counters and data shift registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
        end else if (r_state == IDLE) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            if (i_start) r_tx_sr <= i_byte_in;
        end else begin
            r_div_cnt <= w_cnt_done ? 8'd0 : r_div_cnt + 8'd1;
            if (r_state == SHIFT && w_cnt_done) r_edge_cnt <= r_edge_cnt + 4'd1;
            if (w_shift)  r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            if (w_sample) r_rx_sr <= {r_rx_sr[6:0], i_miso};
        end
    end

endmodule

// File: rtl/spi_periph.sv
// APB slave wrapping the SPI shift engine: register decode, CTRL/TXD/RXD,
// sticky STATUS flags. Optional loopback (CTRL[2]) with SPI_PERIPH_LOOPBACK_EN.
module spi_periph
    import spi_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_n
);
    logic       w_acc, w_wr, w_rd;
    logic       w_sel_ctrl, w_sel_txd, w_sel_rxd, w_sel_stat;
    logic       w_busy, w_done, w_start, w_rd_rxd, w_miso, w_loop;
    logic [7:0] w_byte_out;
    logic [31:0] w_rdata;
    logic       r_cpol, r_cpha;
    logic [7:0] r_div, r_txd, r_rxd;
    logic       r_rx_valid, r_overrun, r_wcol;
    logic       w_unused_ok;

    assign w_acc      = PSEL & PENABLE;
    assign w_wr       = w_acc & PWRITE;
    assign w_rd       = w_acc & ~PWRITE;
    assign w_sel_ctrl = (PADDR == ADDR_W'(OFF_CTRL));
    assign w_sel_txd  = (PADDR == ADDR_W'(OFF_TXD));
    assign w_sel_rxd  = (PADDR == ADDR_W'(OFF_RXD));
    assign w_sel_stat = (PADDR == ADDR_W'(OFF_STATUS));
    assign w_start    = w_wr & w_sel_txd & ~w_busy;
    assign w_rd_rxd   = w_rd & w_sel_rxd;
    assign PREADY     = w_acc;
    assign w_unused_ok = ^PWDATA[31:16];

`ifdef SPI_PERIPH_LOOPBACK_EN
    logic r_loop;
    assign w_loop = r_loop;
    // Loopback control bit, frozen while a transfer runs.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)                           r_loop <= 1'b0;
        else if (w_wr & w_sel_ctrl & ~w_busy)  r_loop <= PWDATA[2];
    end
`else
    assign w_loop = 1'b0;
`endif

    assign w_miso = w_loop ? MOSI : MISO;

    // CTRL and TXD registers; CTRL is frozen while a transfer runs.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_div  <= '0;
            r_txd  <= '0;
        end else begin
            if (w_wr & w_sel_ctrl & ~w_busy) begin
                r_cpol <= PWDATA[0];
                r_cpha <= PWDATA[1];
                r_div  <= PWDATA[15:8];
            end
            if (w_start) r_txd <= PWDATA[7:0];
        end
    end

    // RXD capture and sticky status; a completion beats a same-cycle RXD read.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_rxd      <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_wcol     <= 1'b0;
        end else begin
            if (w_done)        r_rxd <= w_byte_out;
            if (w_done)        r_rx_valid <= 1'b1;
            else if (w_rd_rxd) r_rx_valid <= 1'b0;
            if (w_done && r_rx_valid && !w_rd_rxd)             r_overrun <= 1'b1;
            else if (w_wr && w_sel_stat && PWDATA[STAT_OVR])   r_overrun <= 1'b0;
            if (w_wr && w_sel_txd && w_busy)                   r_wcol <= 1'b1;
            else if (w_wr && w_sel_stat && PWDATA[STAT_WCOL])  r_wcol <= 1'b0;
        end
    end

    // Read mux; unmapped offsets and idle bus return zero.
    always_comb begin
        w_rdata = '0;
        if (w_acc) begin
            if (w_sel_ctrl)      w_rdata = {16'd0, r_div, 5'd0, w_loop, r_cpha, r_cpol};
            else if (w_sel_txd)  w_rdata = {24'd0, r_txd};
            else if (w_sel_rxd)  w_rdata = {24'd0, r_rxd};
            else if (w_sel_stat) w_rdata = {28'd0, r_wcol, r_overrun, r_rx_valid, w_busy};
        end
    end
    assign PRDATA = w_rdata;

    spi_shift_core u_core (
        .i_clk      (PCLK),
        .i_rst_n    (PRESET),
        .i_start    (w_start),
        .i_byte_in  (PWDATA[7:0]),
        .i_cpol     (r_cpol),
        .i_cpha     (r_cpha),
        .i_div      (r_div),
        .i_miso     (w_miso),
        .o_done     (w_done),
        .o_byte_out (w_byte_out),
        .o_busy     (w_busy),
        .o_sclk     (SCLK),
        .o_mosi     (MOSI),
        .o_cs_n     (CS_n)
    );

endmodule
